mem_fill_loader: RTL and testbench

// - Upstream stage of the 1 KiB max/min scanner.
// - Accepts a byte stream over valid/ready and writes it into an internal 1024x8 memory at sequential addresses 0..1023.
// - When the memory is full, pulses scan_start to the scanner and serves its combinational ADDR->DATA reads.
// - Waits for scan_done, then returns to idle.

---
 rtl/mem_fill_loader.sv | 136 +++++++++++++
 tb/tb_mem_fill_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_loader.sv
// mem_fill_loader
//   Upstream stage of the max/min scanner. Collects a byte stream into an
//   internal 2**ADDR_WIDTH x DATA_WIDTH memory, then hands the memory to the
//   scanner. It pulses scan_start and serves the scanner's reads
//   combinationally until scan_done.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   load_en      starts a fill (sampled in IDLE only)
//   s_valid      stream byte valid
//   s_data       stream byte
//   s_ready      stream ready (high only in FILL)
//   rd_addr      scanner read address
//   rd_data      mem[rd_addr], combinational
//   scan_start   one-cycle start pulse to the scanner
//   scan_done    scanner finished
//   busy         high in FILL, START and SCAN
//   fill_count   bytes written in the current fill, 0..2**ADDR_WIDTH
//   checksum     modulo-2**16 sum of the bytes written in the current fill
//
// Build option
//   MEM_FILL_CHECKSUM_EN  builds the checksum accumulator. When it is not
//                         defined, checksum is tied to zero.
//
// state | meaning
// IDLE  | waiting for load_en
// FILL  | accepting stream bytes into mem[0..depth-1]
// START | one-cycle scan_start pulse
// SCAN  | scanner owns the read port; waiting for scan_done

module mem_fill_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  scan_start,
  input  logic                  scan_done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic [15:0]           checksum
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, START, SCAN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     fill_count_q, fill_count_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic                    wr_en;
  logic                    last_wr;
  logic                    fill_enter;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // The write pointer is the low bits of fill_count. It cannot wrap,
  // because the fill ends on the write to the top address.
  assign wr_ptr     = fill_count_q[ADDR_WIDTH-1:0];
  assign wr_en      = (state_q == FILL) && s_valid;
  assign last_wr    = wr_en && (wr_ptr == {ADDR_WIDTH{1'b1}});
  assign fill_enter = (state_q == IDLE) && load_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_en)   state_d = FILL;
      FILL:    if (last_wr)   state_d = START;
      START:                  state_d = SCAN;
      SCAN:    if (scan_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s_ready    = (state_q == FILL);
    scan_start = (state_q == START);
    busy       = (state_q != IDLE);
  end

  // fill_count holds its final value through SCAN and IDLE.
  always_comb begin
    fill_count_d = fill_count_q;
    if (fill_enter)  fill_count_d = '0;
    else if (wr_en)  fill_count_d = fill_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_count_q <= '0;
    else        fill_count_q <= fill_count_d;
  end

  assign fill_count = fill_count_q;

  // The memory is not reset. A read of the address written this cycle
  // returns the old byte.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= s_data;
  end

  assign rd_data = mem_q[rd_addr];

`ifdef MEM_FILL_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (fill_enter)  checksum_d = 16'h0000;
    else if (wr_en)  checksum_d = checksum_q + 16'(s_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum_q <= 16'h0000;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_fill_loader.sv
module tb_mem_fill_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        scan_start;
  logic        scan_done;
  logic        busy;
  logic [10:0] fill_count;
  logic [15:0] checksum;

  int tests = 0;
  int fails = 0;

  int          hs, ss_cnt, ss_cyc, last_hs_cyc, extra_ready;
  logic [15:0] model_ck;

`ifdef MEM_FILL_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_fill_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .scan_start(scan_start), .scan_done(scan_done), .busy(busy),
    .fill_count(fill_count), .checksum(checksum)
  );

  function automatic logic [15:0] exp_ck(input logic [15:0] m);
    return CK_EN ? m : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic end_scan();
    scan_done = 1'b1;
    tick();
    scan_done = 1'b0;
  endtask

  // This task streams byte i^xmask with s_valid held high and records the handshakes.
  // Once 1024 bytes have gone in, it offers 8'hAA; that byte must not be taken.
  // If pulse_at >= 0, it raises load_en in cycle pulse_at and scan_done three cycles later.
  task automatic run_fill(input int max_cyc, input logic [7:0] xmask, input int pulse_at);
    logic accept;
    hs = 0; ss_cnt = 0; ss_cyc = -1; last_hs_cyc = -1; extra_ready = 0; model_ck = 16'h0;
    for (int c = 0; c < max_cyc; c++) begin
      s_valid   = 1'b1;
      s_data    = (hs < 1024) ? (hs[7:0] ^ xmask) : 8'hAA;
      load_en   = (pulse_at >= 0) && (c == pulse_at);
      scan_done = (pulse_at >= 0) && (c == pulse_at + 3);
      #0;
      accept = s_ready;
      if (accept) begin
        last_hs_cyc = c;
        model_ck    = model_ck + {8'h00, s_data};
      end
      if (hs >= 1024 && s_ready) extra_ready++;
      if (scan_start) begin
        ss_cnt++;
        ss_cyc = c;
      end
      tick();
      if (accept) hs++;
    end
    s_valid = 1'b0; load_en = 1'b0; scan_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    rd_addr = '0; scan_done = 1'b0;
    repeat (3) tick();
    tests++; if (s_ready !== 1'b0)        begin fails++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
    tests++; if (scan_start !== 1'b0)     begin fails++; $display("FAIL reset_scan_start got %b exp 0", scan_start); end
    tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (fill_count !== 11'd0)    begin fails++; $display("FAIL reset_fill_count got %0d exp 0", fill_count); end
    tests++; if (checksum !== 16'h0000)   begin fails++; $display("FAIL reset_checksum got %h exp 0000", checksum); end
    rst_n = 1'b1;
    tick();
    tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic check_full_fill(input string tag);
    tests++; if (hs !== 1024)             begin fails++; $display("FAIL %s_handshakes got %0d exp 1024", tag, hs); end
    tests++; if (ss_cnt !== 1)            begin fails++; $display("FAIL %s_scan_start_count got %0d exp 1", tag, ss_cnt); end
    tests++; if (ss_cyc !== last_hs_cyc + 1) begin fails++; $display("FAIL %s_scan_start_cycle got %0d exp %0d", tag, ss_cyc, last_hs_cyc + 1); end
    tests++; if (extra_ready !== 0)       begin fails++; $display("FAIL %s_ready_after_full got %0d exp 0", tag, extra_ready); end
    tests++; if (fill_count !== 11'd1024) begin fails++; $display("FAIL %s_fill_count got %0d exp 1024", tag, fill_count); end
    tests++; if (busy !== 1'b1)           begin fails++; $display("FAIL %s_busy_in_scan got %b exp 1", tag, busy); end
    tests++; if (s_ready !== 1'b0)        begin fails++; $display("FAIL %s_s_ready_in_scan got %b exp 0", tag, s_ready); end
    tests++; if (checksum !== exp_ck(16'hFE00)) begin fails++; $display("FAIL %s_checksum got %h exp %h", tag, checksum, exp_ck(16'hFE00)); end
    rd_addr = 10'd300; #1;
    tests++; if (rd_data !== 8'h2C)       begin fails++; $display("FAIL %s_rd_300 got %h exp 2C", tag, rd_data); end
    rd_addr = 10'd1023; #1;
    tests++; if (rd_data !== 8'hFF)       begin fails++; $display("FAIL %s_rd_1023 got %h exp FF", tag, rd_data); end
    rd_addr = 10'd0; #1;
    tests++; if (rd_data !== 8'h00)       begin fails++; $display("FAIL %s_rd_0_unchanged got %h exp 00", tag, rd_data); end
  endtask

  task automatic test_full_fill();
    start_fill();
    run_fill(1030, 8'h00, -1);
    check_full_fill("full");
  endtask

  task automatic test_scan_wait();
    int drops = 0;
    scan_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy !== 1'b1) drops++;
    end
    tests++; if (drops !== 0)             begin fails++; $display("FAIL scan_wait_busy_drops got %0d exp 0", drops); end
    end_scan();
    tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL scan_done_busy got %b exp 0", busy); end
    tests++; if (fill_count !== 11'd1024) begin fails++; $display("FAIL idle_fill_count_hold got %0d exp 1024", fill_count); end
    tests++; if (checksum !== exp_ck(16'hFE00)) begin fails++; $display("FAIL idle_checksum_hold got %h exp %h", checksum, exp_ck(16'hFE00)); end
    start_fill();
    tests++; if (fill_count !== 11'd0)    begin fails++; $display("FAIL restart_fill_count got %0d exp 0", fill_count); end
    tests++; if (s_ready !== 1'b1)        begin fails++; $display("FAIL restart_s_ready got %b exp 1", s_ready); end
    tests++; if (checksum !== 16'h0000)   begin fails++; $display("FAIL restart_checksum got %h exp 0000", checksum); end
  endtask

  // This test runs while the DUT is still in FILL, straight after the restart.
  task automatic test_stall();
    logic       v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] d [4] = '{8'h11, 8'h99, 8'h99, 8'h22};
    for (int i = 0; i < 4; i++) begin
      s_valid = v[i]; s_data = d[i];
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    tests++; if (fill_count !== 11'd2)    begin fails++; $display("FAIL stall_fill_count got %0d exp 2", fill_count); end
    tests++; if (checksum !== exp_ck(16'h0033)) begin fails++; $display("FAIL stall_checksum got %h exp %h", checksum, exp_ck(16'h0033)); end
    rd_addr = 10'd0; #1;
    tests++; if (rd_data !== 8'h11)       begin fails++; $display("FAIL stall_mem0 got %h exp 11", rd_data); end
    rd_addr = 10'd1; #1;
    tests++; if (rd_data !== 8'h22)       begin fails++; $display("FAIL stall_mem1 got %h exp 22", rd_data); end
    rd_addr = 10'd2; #1;
    tests++; if (rd_data !== 8'h02)       begin fails++; $display("FAIL stall_mem2_untouched got %h exp 02", rd_data); end
  endtask

  task automatic test_read_during_write();
    rd_addr = 10'd2; s_valid = 1'b1; s_data = 8'h5A; #1;
    tests++; if (rd_data !== 8'h02)       begin fails++; $display("FAIL rdw_old_data got %h exp 02", rd_data); end
    tick();
    s_valid = 1'b0; #1;
    tests++; if (rd_data !== 8'h5A)       begin fails++; $display("FAIL rdw_new_data got %h exp 5A", rd_data); end
    tests++; if (fill_count !== 11'd3)    begin fails++; $display("FAIL rdw_fill_count got %0d exp 3", fill_count); end
  endtask

  task automatic test_reset_mid_fill();
    int ss_seen = 0;
    int busy_seen = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    start_fill();
    s_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      s_data = i[7:0] ^ 8'h0F;
      tick();
    end
    tests++; if (fill_count !== 11'd500)  begin fails++; $display("FAIL pre_reset_fill_count got %0d exp 500", fill_count); end
    rst_n = 1'b0; #1;
    tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL midreset_busy got %b exp 0", busy); end
    tests++; if (fill_count !== 11'd0)    begin fails++; $display("FAIL midreset_fill_count got %0d exp 0", fill_count); end
    tests++; if (s_ready !== 1'b0)        begin fails++; $display("FAIL midreset_s_ready got %b exp 0", s_ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (scan_start) ss_seen++;
      if (busy) busy_seen++;
    end
    s_valid = 1'b0;
    tests++; if (ss_seen !== 0)           begin fails++; $display("FAIL midreset_scan_start got %0d exp 0", ss_seen); end
    tests++; if (busy_seen !== 0)         begin fails++; $display("FAIL midreset_idle_busy got %0d exp 0", busy_seen); end
    start_fill();
    run_fill(1030, 8'h00, -1);
    check_full_fill("after_reset");
    end_scan();
  endtask

  task automatic test_ignored_inputs();
    start_fill();
    run_fill(1030, 8'h00, 100);
    check_full_fill("ignore");
    end_scan();
    tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL ignore_back_to_idle got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_scan_wait();
    test_stall();
    test_read_during_write();
    test_reset_mid_fill();
    test_ignored_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
